sysid_verify_ctrl: RTL and testbench

- Boot-time sequencer that acts as an Avalon-MM read master on the system ID slave.
- Reads word 0 (ID) and word 1 (timestamp), compares both against build-time expected values, and retries on mismatch or timeout.
- Publishes a sticky pass/fail status to reset-release and host status logic.
- Sits between the fabric interconnect and the board bring-up/status register block.

---
 rtl/sysid_verify_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sysid_verify_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sysid_verify_ctrl.sv
// Boot-time system ID verifier: reads ID and timestamp words over Avalon-MM,
// compares them with build-time constants, retries on failure, and reports a sticky status.
module sysid_verify_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'h5824_2BE7,
    parameter logic [31:0] EXPECTED_TS    = 32'h4E09_25DA,
    parameter int          CHECK_TS       = 1,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter int          RETRY_GAP      = 16,
    parameter int          AUTO_START     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [3:0]  retry_count,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        RD_TS,
        CHECK,
        GAP,
        DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRIES);
    localparam logic [7:0]  GAP_LOAD      = 8'(RETRY_GAP - 1);

    state_t      state;
    logic        launch_pending;
    logic [15:0] stall_cnt;
    logic [7:0]  gap_cnt;

    logic read_done;
    logic read_timeout;
    logic id_bad;
    logic ts_bad;
    logic can_retry;

    assign read_done    = avm_read && !avm_waitrequest;
    assign read_timeout = avm_read && avm_waitrequest && (stall_cnt == TIMEOUT_LIMIT);
    assign id_bad       = (id_value != EXPECTED_ID);
    assign ts_bad       = (CHECK_TS != 0) && (ts_value != EXPECTED_TS);
    assign can_retry    = (retry_count < RETRY_LIMIT);

    // NOTE: every register below is written with <= so all updates in a cycle
    // see the same pre-edge values; reset is sampled on the clock edge, not asynchronously.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            launch_pending <= (AUTO_START != 0);
            stall_cnt      <= '0;
            gap_cnt        <= '0;
            avm_address    <= 1'b0;
            avm_read       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            id_mismatch    <= 1'b0;
            ts_mismatch    <= 1'b0;
            timeout_err    <= 1'b0;
            retry_count    <= '0;
            id_value       <= '0;
            ts_value       <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    launch_pending <= 1'b0;
                    if (start || (state == IDLE && launch_pending)) begin
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        stall_cnt   <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout_err <= 1'b0;
                        retry_count <= '0;
                    end
                end

                RD_ID, RD_TS: begin
                    if (read_done) begin
                        stall_cnt <= '0;
                        if (state == RD_ID) begin
                            id_value    <= avm_readdata;
                            avm_address <= 1'b1;
                            state       <= RD_TS;
                        end else begin
                            ts_value <= avm_readdata;
                            avm_read <= 1'b0;
                            state    <= CHECK;
                        end
                    end else if (read_timeout) begin
                        // Abandon the attempt without comparing; retry rules match CHECK.
                        avm_read    <= 1'b0;
                        timeout_err <= 1'b1;
                        if (can_retry) begin
                            state       <= GAP;
                            retry_count <= retry_count + 4'd1;
                            gap_cnt     <= GAP_LOAD;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= 1'b0;
                        end
                    end else if (avm_waitrequest) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end

                CHECK: begin
                    id_mismatch <= id_bad;
                    ts_mismatch <= ts_bad;
                    if (!id_bad && !ts_bad) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (can_retry) begin
                        state       <= GAP;
                        retry_count <= retry_count + 4'd1;
                        gap_cnt     <= GAP_LOAD;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= 1'b0;
                    end
                end

                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state       <= RD_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        stall_cnt   <= '0;
                        id_mismatch <= 1'b0;
                        ts_mismatch <= 1'b0;
                        timeout_err <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_verify_ctrl.sv
// Directed bench for sysid_verify_ctrl: one instance with defaults (TS checked),
// one with CHECK_TS = 0 and TIMEOUT_CYCLES = 8, each with a small Avalon slave model.
module tb_sysid_verify_ctrl;

    localparam logic [31:0] EXP_ID = 32'h5824_2BE7;
    localparam logic [31:0] EXP_TS = 32'h4E09_25DA;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    // instance a: defaults
    logic        addr_a, read_a, wr_a, busy_a, done_a, pass_a, idm_a, tsm_a, to_a;
    logic [31:0] rdata_a, idv_a, tsv_a;
    logic [3:0]  rc_a;
    logic [31:0] id_a, ts_a;
    int          stall_a, scnt_a;

    // instance b: timestamp not compared, short timeout
    logic        addr_b, read_b, wr_b, busy_b, done_b, pass_b, idm_b, tsm_b, to_b;
    logic [31:0] rdata_b, idv_b, tsv_b;
    logic [3:0]  rc_b;
    logic [31:0] id_b, ts_b;
    int          stall_b, scnt_b;

    sysid_verify_ctrl dut_a (
        .clk(clk), .reset_n(reset_n), .start(start),
        .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rdata_a),
        .avm_waitrequest(wr_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .id_mismatch(idm_a), .ts_mismatch(tsm_a), .timeout_err(to_a),
        .retry_count(rc_a), .id_value(idv_a), .ts_value(tsv_a)
    );

    sysid_verify_ctrl #(.CHECK_TS(0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start),
        .avm_address(addr_b), .avm_read(read_b), .avm_readdata(rdata_b),
        .avm_waitrequest(wr_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .id_mismatch(idm_b), .ts_mismatch(tsm_b), .timeout_err(to_b),
        .retry_count(rc_b), .id_value(idv_b), .ts_value(tsv_b)
    );

    // Slave models: stall each read for stall_x cycles, then return the word.
    assign wr_a    = read_a && (scnt_a < stall_a);
    assign rdata_a = addr_a ? ts_a : id_a;
    assign wr_b    = read_b && (scnt_b < stall_b);
    assign rdata_b = addr_b ? ts_b : id_b;

    always @(posedge clk) begin
        if (!read_a || !wr_a) scnt_a <= 0;
        else                  scnt_a <= scnt_a + 1;
        if (!read_b || !wr_b) scnt_b <= 0;
        else                  scnt_b <= scnt_b + 1;
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_done(input bit which);
        while (((which == 1'b0) ? done_a : done_b) !== 1'b1 && cyc < 2000) tick();
    endtask

    initial begin
        scnt_a = 0; scnt_b = 0;
        id_a = EXP_ID; ts_a = EXP_TS; stall_a = 0;
        id_b = EXP_ID; ts_b = EXP_TS; stall_b = 0;

        // Reset state
        hold_reset();
        check("rst_read", {31'd0, read_a}, 32'd0);
        check("rst_busy_done_pass", {29'd0, busy_a, done_a, pass_a}, 32'd0);
        check("rst_retry", {28'd0, rc_a}, 32'd0);
        check("rst_id_value", idv_a, 32'd0);

        // Nominal: no stalls, done on cycle 4
        release_reset();
        tick();
        check("nom_c1_read_addr", {30'd0, read_a, addr_a}, 32'd2);
        check("nom_c1_busy", {31'd0, busy_a}, 32'd1);
        tick();
        check("nom_c2_read_addr", {30'd0, read_a, addr_a}, 32'd3);
        check("nom_c2_id_value", idv_a, EXP_ID);
        tick();
        check("nom_c3_read", {31'd0, read_a}, 32'd0);
        check("nom_c3_done", {31'd0, done_a}, 32'd0);
        tick();
        check("nom_c4_done_pass", {30'd0, done_a, pass_a}, 32'd3);
        check("nom_ts_value", tsv_a, EXP_TS);
        check("nom_retry", {28'd0, rc_a}, 32'd0);
        check("nom_busy", {31'd0, busy_a}, 32'd0);

        // Five stall cycles per read, with a start pulse mid-sequence (ignored)
        hold_reset();
        stall_a = 5;
        release_reset();
        repeat (3) tick();
        check("stall_addr_held", {30'd0, read_a, addr_a}, 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(1'b0);
        check("stall_done_cycle", cyc, 14);
        check("stall_pass", {31'd0, pass_a}, 32'd1);
        check("stall_ts_value", tsv_a, EXP_TS);

        // ID always wrong: four attempts, 16-cycle gaps, done on cycle 61
        hold_reset();
        stall_a = 0;
        id_a = 32'h1234_5678;
        release_reset();
        while (cyc < 10) tick();
        check("gap_read_low", {31'd0, read_a}, 32'd0);
        check("gap_busy_retry", {27'd0, busy_a, rc_a}, 32'h11);
        wait_done(1'b0);
        check("retry_done_cycle", cyc, 61);
        check("retry_pass", {31'd0, pass_a}, 32'd0);
        check("retry_flags", {29'd0, idm_a, tsm_a, to_a}, 32'd4);
        check("retry_count", {28'd0, rc_a}, 32'd3);
        check("retry_id_value", idv_a, 32'h1234_5678);

        // Wrong timestamp, compare disabled on b
        hold_reset();
        id_a = EXP_ID;
        ts_b = 32'hDEAD_BEEF;
        release_reset();
        wait_done(1'b1);
        check("nots_done_cycle", cyc, 4);
        check("nots_pass", {31'd0, pass_b}, 32'd1);
        check("nots_ts_value", tsv_b, 32'hDEAD_BEEF);
        check("nots_ts_mismatch", {31'd0, tsm_b}, 32'd0);

        // Eight stalls then data: completes exactly at the timeout count
        hold_reset();
        ts_b = EXP_TS;
        stall_b = 8;
        release_reset();
        wait_done(1'b1);
        check("edge_done_cycle", cyc, 20);
        check("edge_pass_timeout", {30'd0, pass_b, to_b}, 32'd2);

        // Waitrequest stuck: read high 9 cycles, timeout, retries, done on cycle 85
        hold_reset();
        stall_b = 1000;
        release_reset();
        while (cyc < 9) tick();
        check("to_read_before", {31'd0, read_b}, 32'd1);
        tick();
        check("to_read_dropped", {31'd0, read_b}, 32'd0);
        check("to_flag", {31'd0, to_b}, 32'd1);
        wait_done(1'b1);
        check("to_done_cycle", cyc, 85);
        check("to_pass", {31'd0, pass_b}, 32'd0);
        check("to_flags", {29'd0, idm_b, tsm_b, to_b}, 32'd1);
        check("to_retry", {28'd0, rc_b}, 32'd3);

        // Reset during TS stall, then auto relaunch
        hold_reset();
        stall_a = 5;
        stall_b = 0;
        release_reset();
        while (cyc < 9) tick();
        check("mid_in_ts", {30'd0, read_a, addr_a}, 32'd3);
        reset_n = 1'b0;
        tick();
        check("mid_rst_read", {31'd0, read_a}, 32'd0);
        check("mid_rst_outs", {28'd0, busy_a, done_a, pass_a, to_a}, 32'd0);
        check("mid_rst_id_value", idv_a, 32'd0);
        release_reset();
        wait_done(1'b0);
        check("relaunch_done_cycle", cyc, 14);
        check("relaunch_pass", {31'd0, pass_a}, 32'd1);

        // start from DONE relaunches
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        check("restart_busy_done", {30'd0, busy_a, done_a}, 32'd2);
        wait_done(1'b0);
        check("restart_done_cycle", cyc, 14);
        check("restart_pass", {31'd0, pass_a}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
